ps2_kbd_ctrl: RTL and testbench

Sequencing controller between the PS/2 scan-code receiver (byte FIFO with ready/nextdata_n pop interface) and the consumers (display and CPU MMIO). It pops bytes from the receiver and decodes the E0/F0 prefix grammar into single key events. It also suppresses typematic repeats, tracks the held key, counts presses and flags protocol or overflow errors. Events leave through a one-entry valid/ready output register.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_evt_reg.sv | 33 +++
 rtl/ps2_kbd_ctrl.sv | 155 +++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard path: prefix bytes, the decoder
// state encoding and the key-event record carried to the consumers.
package ps2_pkg;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } kbd_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic       rep;
      logic [7:0] code;
   } kbd_evt_t;

   localparam int EVT_W = $bits(kbd_evt_t);

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == SC_EXT) || (b == SC_BRK);
   endfunction

endpackage

// File: rtl/ps2_evt_reg.sv
// One-entry valid/ready holding register for decoded key events.
module ps2_evt_reg
   import ps2_pkg::*;
(
   input  logic             clk,
   input  logic             clrn,
   input  logic             load,
   input  logic [EVT_W-1:0] evt_in,
   input  logic             ready,
   output logic             valid,
   output logic [EVT_W-1:0] evt_out
);

   logic             vld_p1;
   logic [EVT_W-1:0] evt_p1;

   // A load in the same cycle as an accept keeps the register full.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         vld_p1 <= 1'b0;
         evt_p1 <= '0;
      end else if (load) begin
         vld_p1 <= 1'b1;
         evt_p1 <= evt_in;
      end else if (vld_p1 && ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign valid   = vld_p1;
   assign evt_out = evt_p1;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Pops scan bytes from the PS/2 receiver FIFO, decodes E0/F0 prefixes into key
// events, filters typematic repeats and tracks the held key and press count.
module ps2_kbd_ctrl
   import ps2_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYC     = 24'd5_000_000,
   parameter bit          SUPPRESS_REPEAT = 1'b1,
   parameter int          CNT_W           = 8
)(
   input  logic             clk,
   input  logic             clrn,
   input  logic             kbd_ready,
   input  logic [7:0]       kbd_data,
   input  logic             kbd_overflow,
   output logic             kbd_nextdata_n,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [7:0]       ev_code,
   output logic             ev_ext,
   output logic             ev_break,
   output logic             ev_rep,
   output logic             key_down,
   output logic [7:0]       held_code,
   output logic [CNT_W-1:0] press_cnt,
   output logic             err,
   input  logic             err_clr
);

   kbd_state_t  state, state_nxt;
   logic        gap_p0;
   logic [23:0] timer_p0;
   logic        held_ext;

   logic        pop;
   logic        timeout;
   logic        emit, emit_ext, emit_brk, proto_err;
   logic        key_match, is_rep, new_press, rel_held, ev_load;
   kbd_evt_t    evt_in, evt_q;
   logic [EVT_W-1:0] evt_out;

   // The receiver needs a cycle to present its next byte, hence the gap.
   assign pop            = kbd_ready && !gap_p0 && (!ev_valid || ev_ready);
   assign kbd_nextdata_n = !pop;

   assign timeout = (state != IDLE) && !pop && (timer_p0 == TIMEOUT_CYC - 24'd1);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      emit_ext  = 1'b0;
      emit_brk  = 1'b0;
      proto_err = 1'b0;
      if (pop) begin
         unique case (state)
            IDLE: begin
               if (kbd_data == SC_EXT)      state_nxt = EXT;
               else if (kbd_data == SC_BRK) state_nxt = BRK;
               else                         emit      = 1'b1;
            end
            EXT: begin
               if (kbd_data == SC_BRK) begin
                  state_nxt = EXT_BRK;
               end else if (kbd_data == SC_EXT) begin
                  proto_err = 1'b1;
               end else begin
                  emit      = 1'b1;
                  emit_ext  = 1'b1;
                  state_nxt = IDLE;
               end
            end
            BRK: begin
               state_nxt = IDLE;
               if (is_prefix(kbd_data)) begin
                  proto_err = 1'b1;
               end else begin
                  emit     = 1'b1;
                  emit_brk = 1'b1;
               end
            end
            EXT_BRK: begin
               state_nxt = IDLE;
               if (is_prefix(kbd_data)) begin
                  proto_err = 1'b1;
               end else begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  emit_brk = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else if (timeout) begin
         state_nxt = IDLE;
      end
   end

   assign key_match = key_down && (held_ext == emit_ext) && (held_code == kbd_data);
   assign is_rep    = emit && !emit_brk && key_match;
   assign new_press = emit && !emit_brk && !key_match;
   assign rel_held  = emit && emit_brk && key_match;
   assign ev_load   = emit && (emit_brk || !is_rep || !SUPPRESS_REPEAT);

   assign evt_in.ext  = emit_ext;
   assign evt_in.brk  = emit_brk;
   assign evt_in.rep  = is_rep;
   assign evt_in.code = kbd_data;

   // Decode stage: byte popped this cycle drives the event register and key state.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         gap_p0    <= 1'b0;
         timer_p0  <= '0;
         key_down  <= 1'b0;
         held_code <= '0;
         held_ext  <= 1'b0;
         press_cnt <= '0;
         err       <= 1'b0;
      end else begin
         gap_p0 <= pop;
         if (pop || (state == IDLE) || timeout) timer_p0 <= '0;
         else                                   timer_p0 <= timer_p0 + 24'd1;
         if (new_press) begin
            key_down  <= 1'b1;
            held_code <= kbd_data;
            held_ext  <= emit_ext;
            press_cnt <= press_cnt + CNT_W'(1);
         end else if (rel_held) begin
            key_down <= 1'b0;
         end
         err <= (err && !err_clr) || kbd_overflow || proto_err || timeout;
      end
   end

   ps2_evt_reg u_evt_reg (
      .clk     (clk),
      .clrn    (clrn),
      .load    (ev_load),
      .evt_in  (evt_in),
      .ready   (ev_ready),
      .valid   (ev_valid),
      .evt_out (evt_out)
   );

   assign evt_q    = evt_out;
   assign ev_code  = evt_q.code;
   assign ev_ext   = evt_q.ext;
   assign ev_break = evt_q.brk;
   assign ev_rep   = evt_q.rep;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench: two controllers (repeat suppression on/off) share one byte
// stream; a grammar-level model predicts the events each should deliver.
module tb_ps2_kbd_ctrl;

   logic clk = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   logic kbd_overflow = 1'b0;
   logic err_clr = 1'b0;
   logic ev_ready;

   logic       kbd_ready0, kbd_ready1, nd_n0, nd_n1;
   logic [7:0] kbd_data0, kbd_data1;
   logic       ev_valid0, ev_ext0, ev_brk0, ev_rep0, key_down0, err0;
   logic       ev_valid1, ev_ext1, ev_brk1, ev_rep1, key_down1, err1;
   logic [7:0] ev_code0, held_code0, press_cnt0;
   logic [7:0] ev_code1, held_code1, press_cnt1;

   // Receiver FIFO model: shared storage, one read pointer per controller.
   logic [7:0] fmem [1024];
   logic [9:0] wp  = '0;
   logic [9:0] rp0 = '0;
   logic [9:0] rp1 = '0;

   assign kbd_ready0 = (rp0 != wp);
   assign kbd_ready1 = (rp1 != wp);
   assign kbd_data0  = fmem[rp0];
   assign kbd_data1  = fmem[rp1];

   always @(posedge clk) begin
      if (!nd_n0) rp0 <= rp0 + 10'd1;
      if (!nd_n1) rp1 <= rp1 + 10'd1;
   end

   ps2_kbd_ctrl #(.TIMEOUT_CYC(24'd16), .SUPPRESS_REPEAT(1'b1), .CNT_W(8)) dut0 (
      .clk(clk), .clrn(clrn), .kbd_ready(kbd_ready0), .kbd_data(kbd_data0),
      .kbd_overflow(kbd_overflow), .kbd_nextdata_n(nd_n0), .ev_valid(ev_valid0),
      .ev_ready(ev_ready), .ev_code(ev_code0), .ev_ext(ev_ext0), .ev_break(ev_brk0),
      .ev_rep(ev_rep0), .key_down(key_down0), .held_code(held_code0),
      .press_cnt(press_cnt0), .err(err0), .err_clr(err_clr)
   );

   ps2_kbd_ctrl #(.TIMEOUT_CYC(24'd16), .SUPPRESS_REPEAT(1'b0), .CNT_W(8)) dut1 (
      .clk(clk), .clrn(clrn), .kbd_ready(kbd_ready1), .kbd_data(kbd_data1),
      .kbd_overflow(kbd_overflow), .kbd_nextdata_n(nd_n1), .ev_valid(ev_valid1),
      .ev_ready(ev_ready), .ev_code(ev_code1), .ev_ext(ev_ext1), .ev_break(ev_brk1),
      .ev_rep(ev_rep1), .key_down(key_down1), .held_code(held_code1),
      .press_cnt(press_cnt1), .err(err1), .err_clr(err_clr)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int pops0   = 0;
   int pops1   = 0;
   int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

   // Expected events packed as {ext, brk, rep, code}
   logic [10:0] exp0 [$];
   logic [10:0] exp1 [$];

   // Reference model: pending prefixes plus the held key
   bit         m_e0, m_f0, m_down, m_hext, m_err;
   logic [7:0] m_held, m_cnt;

   logic [7:0] pool [5] = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key_event(input bit ext, input bit brk, input logic [7:0] code);
      bit same;
      same = m_down && (m_hext == ext) && (m_held == code);
      if (brk) begin
         exp0.push_back({ext, 1'b1, 1'b0, code});
         exp1.push_back({ext, 1'b1, 1'b0, code});
         if (same) m_down = 1'b0;
      end else if (same) begin
         exp1.push_back({ext, 1'b0, 1'b1, code});
      end else begin
         exp0.push_back({ext, 1'b0, 1'b0, code});
         exp1.push_back({ext, 1'b0, 1'b0, code});
         m_down = 1'b1;
         m_hext = ext;
         m_held = code;
         m_cnt  = m_cnt + 8'd1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      fmem[wp] = b;
      wp = wp + 10'd1;
      if (b == 8'hE0) begin
         if (m_f0) begin m_err = 1'b1; m_e0 = 1'b0; m_f0 = 1'b0; end
         else if (m_e0) m_err = 1'b1;
         else m_e0 = 1'b1;
      end else if (b == 8'hF0) begin
         if (m_f0) begin m_err = 1'b1; m_e0 = 1'b0; m_f0 = 1'b0; end
         else m_f0 = 1'b1;
      end else begin
         key_event(m_e0, m_f0, b);
         m_e0 = 1'b0;
         m_f0 = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_e0 = 0; m_f0 = 0; m_down = 0; m_hext = 0; m_err = 0;
      m_held = '0; m_cnt = '0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(rp0 == wp && rp1 == wp && exp0.size() == 0 && exp1.size() == 0
               && !ev_valid0 && !ev_valid1) && n < 600) begin
         tick();
         n++;
      end
      chk({name, "_drain"}, 32'(n < 600), 32'd1);
   endtask

   task automatic check_state(input string name);
      chk({name, "_keydown0"}, 32'(key_down0), 32'(m_down));
      chk({name, "_keydown1"}, 32'(key_down1), 32'(m_down));
      if (m_down) begin
         chk({name, "_held0"}, 32'(held_code0), 32'(m_held));
         chk({name, "_held1"}, 32'(held_code1), 32'(m_held));
      end
      chk({name, "_cnt0"}, 32'(press_cnt0), 32'(m_cnt));
      chk({name, "_cnt1"}, 32'(press_cnt1), 32'(m_cnt));
      chk({name, "_err0"}, 32'(err0), 32'(m_err));
      chk({name, "_err1"}, 32'(err1), 32'(m_err));
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      m_err = 1'b0;
      chk("errclr0", 32'(err0), 32'd0);
      chk("errclr1", 32'(err1), 32'd0);
   endtask

   task automatic check_reset_vals();
      chk("rst_ndn0",  32'(nd_n0), 32'd1);
      chk("rst_vld0",  32'(ev_valid0), 32'd0);
      chk("rst_vld1",  32'(ev_valid1), 32'd0);
      chk("rst_evt0",  32'({ev_ext0, ev_brk0, ev_rep0, ev_code0}), 32'd0);
      chk("rst_kd0",   32'(key_down0), 32'd0);
      chk("rst_held0", 32'(held_code0), 32'd0);
      chk("rst_cnt0",  32'(press_cnt0), 32'd0);
      chk("rst_cnt1",  32'(press_cnt1), 32'd0);
      chk("rst_err0",  32'(err0), 32'd0);
   endtask

   task automatic ready_driver();
      int low = 0;
      ev_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 2)      ev_ready = 1'b0;
         else if (rdy_mode == 1) ev_ready = ($urandom_range(0, 3) != 0) || (low >= 3);
         else                    ev_ready = 1'b1;
         low = ev_ready ? 0 : low + 1;
      end
   endtask

   task automatic monitor();
      bit          prev_hold0 = 0, prev_hold1 = 0, prev_pop0 = 0, prev_pop1 = 0;
      logic [10:0] prev0 = '0, prev1 = '0, cur0, cur1, e;
      forever begin
         @(negedge clk);
         cur0 = {ev_ext0, ev_brk0, ev_rep0, ev_code0};
         cur1 = {ev_ext1, ev_brk1, ev_rep1, ev_code1};
         if (!clrn) begin
            prev_hold0 = 0; prev_hold1 = 0; prev_pop0 = 0; prev_pop1 = 0;
         end else begin
            if (ev_valid0 && ev_ready) begin
               e = (exp0.size() > 0) ? exp0.pop_front() : 11'h7FF;
               chk("event0", 32'(cur0), 32'(e));
            end
            if (ev_valid1 && ev_ready) begin
               e = (exp1.size() > 0) ? exp1.pop_front() : 11'h7FF;
               chk("event1", 32'(cur1), 32'(e));
            end
            if (prev_hold0) begin
               chk("hold_vld0", 32'(ev_valid0), 32'd1);
               chk("hold_evt0", 32'(cur0), 32'(prev0));
            end
            if (prev_hold1) begin
               chk("hold_vld1", 32'(ev_valid1), 32'd1);
               chk("hold_evt1", 32'(cur1), 32'(prev1));
            end
            if (!nd_n0) begin
               pops0++;
               chk("pop_ready0", 32'(kbd_ready0), 32'd1);
               chk("pop_gap0", 32'(prev_pop0), 32'd0);
            end
            if (!nd_n1) begin
               pops1++;
               chk("pop_ready1", 32'(kbd_ready1), 32'd1);
               chk("pop_gap1", 32'(prev_pop1), 32'd0);
            end
            prev_hold0 = ev_valid0 && !ev_ready;
            prev_hold1 = ev_valid1 && !ev_ready;
            prev0 = cur0;
            prev1 = cur1;
            prev_pop0 = !nd_n0;
            prev_pop1 = !nd_n1;
         end
      end
   endtask

   initial begin
      int p0, p1, n;
      logic [7:0] code;
      model_reset();
      fork
         ready_driver();
         monitor();
      join_none

      repeat (3) tick();
      check_reset_vals();
      clrn = 1'b1;
      tick();

      // make then break of one key
      p0 = pops0;
      push_byte(8'h1C);
      wait_idle("mk1c");
      check_state("mk1c");
      push_byte(8'hF0); push_byte(8'h1C);
      wait_idle("bk1c");
      check_state("bk1c");
      chk("pops_3", 32'(pops0 - p0), 32'd3);

      // extended make / break
      push_byte(8'hE0); push_byte(8'h75);
      push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
      wait_idle("ext75");
      check_state("ext75");

      // typematic repeats
      push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
      push_byte(8'hF0); push_byte(8'h1C);
      wait_idle("rep");
      check_state("rep");

      // back-pressure: only one byte may be taken while the consumer stalls
      rdy_mode = 2;
      tick(); tick();
      p0 = pops0; p1 = pops1;
      push_byte(8'h15); push_byte(8'h1D); push_byte(8'h24);
      push_byte(8'h2D); push_byte(8'h2C);
      repeat (20) tick();
      chk("stall_pops0", 32'(pops0 - p0), 32'd1);
      chk("stall_pops1", 32'(pops1 - p1), 32'd1);
      chk("stall_vld0", 32'(ev_valid0), 32'd1);
      chk("stall_code0", 32'(ev_code0), 32'h15);
      rdy_mode = 0;
      wait_idle("stall");
      check_state("stall");

      // abandoned break prefix
      push_byte(8'hF0);
      n = 0;
      while ((rp0 != wp || rp1 != wp) && n < 50) begin tick(); n++; end
      repeat (20) tick();
      m_e0 = 0; m_f0 = 0; m_err = 1'b1;
      chk("tmo_err0", 32'(err0), 32'd1);
      chk("tmo_err1", 32'(err1), 32'd1);
      push_byte(8'h1C);
      wait_idle("tmo");
      check_state("tmo");
      clear_err();

      // receiver overflow
      kbd_overflow = 1'b1;
      tick();
      kbd_overflow = 1'b0;
      m_err = 1'b1;
      check_state("ovf");
      clear_err();

      // reset in the middle of an extended sequence
      push_byte(8'hE0);
      n = 0;
      while ((rp0 != wp || rp1 != wp) && n < 50) begin tick(); n++; end
      tick();
      clrn = 1'b0;
      #1;
      check_reset_vals();
      tick();
      clrn = 1'b1;
      model_reset();
      tick();
      push_byte(8'h75);
      wait_idle("rst75");
      check_state("rst75");

      // randomized sequences with occasional illegal prefix orders
      rdy_mode = 1;
      for (int i = 0; i < 80; i++) begin
         code = pool[$urandom_range(0, 4)];
         case ($urandom_range(0, 9))
            0, 1, 2: push_byte(code);
            3, 4:    begin push_byte(8'hF0); push_byte(code); end
            5, 6:    begin push_byte(8'hE0); push_byte(code); end
            7:       begin push_byte(8'hE0); push_byte(8'hF0); push_byte(code); end
            8:       begin push_byte(8'hE0); push_byte(8'hE0); push_byte(code); end
            default: begin push_byte(8'hF0); push_byte(8'hE0); push_byte(code); end
         endcase
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle("rand");
      rdy_mode = 0;
      tick();
      check_state("rand");
      clear_err();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
